// File: rtl/ipm_sfifo_ctrl_v2_if.sv
// rtl/ipm_sfifo_ctrl_v2_if.sv - user, RAM-port and status signals of the sync FIFO controller
interface ipm_sfifo_ctrl_v2_if #(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_DATA_WIDTH  = 32
);
  logic                     flush;
  logic                     w_en;
  logic                     r_en;
  logic [c_DEPTH_WIDTH:0]   af_thresh;
  logic [c_DEPTH_WIDTH:0]   ae_thresh;
  logic                     clr_err;
  logic                     ram_we;
  logic [c_DEPTH_WIDTH-1:0] waddr;
  logic                     ram_re;
  logic [c_DEPTH_WIDTH-1:0] raddr;
  logic [c_DATA_WIDTH-1:0]  ram_rdata;
  logic [c_DATA_WIDTH-1:0]  rdata;
  logic                     rvalid;
  logic                     wfull;
  logic                     almost_full;
  logic                     rempty;
  logic                     almost_empty;
  logic [c_DEPTH_WIDTH:0]   water_level;
  logic                     overflow;
  logic                     underflow;

  modport slave (
    input  flush, w_en, r_en, af_thresh, ae_thresh, clr_err, ram_rdata,
    output ram_we, waddr, ram_re, raddr, rdata, rvalid, wfull, almost_full,
           rempty, almost_empty, water_level, overflow, underflow
  );

  modport master (
    output flush, w_en, r_en, af_thresh, ae_thresh, clr_err, ram_rdata,
    input  ram_we, waddr, ram_re, raddr, rdata, rvalid, wfull, almost_full,
           rempty, almost_empty, water_level, overflow, underflow
  );
endinterface

// File: rtl/ipm_sfifo_ctrl_v2.sv
// rtl/ipm_sfifo_ctrl_v2.sv - sync FIFO controller for an external RAM, standard or FWFT read
// Sticky overflow/underflow flags exist only when FIFO_CTRL_ERR_FLAG_EN is defined.
module ipm_sfifo_ctrl_v2 #(
  parameter int    c_DEPTH_WIDTH = 9,
  parameter int    c_DATA_WIDTH  = 32,
  parameter string c_FWFT        = "OFF"
) (
  input logic               clk,
  input logic               rst_n,
  ipm_sfifo_ctrl_v2_if.slave bus
);
  localparam logic [c_DEPTH_WIDTH:0] FULL_LVL = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
  localparam logic [c_DEPTH_WIDTH:0] ONE      = {{c_DEPTH_WIDTH{1'b0}}, 1'b1};

  logic [c_DEPTH_WIDTH:0] wptr;
  logic [c_DEPTH_WIDTH:0] rptr;
  logic [c_DEPTH_WIDTH:0] level;
  logic                   wr_acc;
  logic                   pop;

  assign bus.wfull        = (level == FULL_LVL);
  assign bus.almost_full  = (level >= bus.af_thresh);
  assign bus.almost_empty = (level <= bus.ae_thresh);
  assign bus.water_level  = level;
  assign bus.waddr        = wptr[c_DEPTH_WIDTH-1:0];
  assign bus.raddr        = rptr[c_DEPTH_WIDTH-1:0];

  assign wr_acc     = bus.w_en && !bus.wfull && !bus.flush;
  assign pop        = bus.r_en && !bus.rempty && !bus.flush;
  assign bus.ram_we = wr_acc;

  // rptr follows RAM reads; level follows the user-visible pushes and pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_acc)
        wptr <= wptr + ONE;
      if (bus.ram_re)
        rptr <= rptr + ONE;
      case ({wr_acc, pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  if (c_FWFT == "ON") begin : g_fwft
    logic [1:0]              st_cnt;
    logic                    inflight;
    logic [c_DATA_WIDTH-1:0] st0;
    logic [c_DATA_WIDTH-1:0] st1;
    logic [1:0]              st_next;

    // entries held after this edge: current, plus the landing read, minus the pop
    assign st_next    = st_cnt + (inflight ? 2'd1 : 2'd0) - (pop ? 2'd1 : 2'd0);
    assign bus.ram_re = (wptr != rptr) && (st_next < 2'd2) && !bus.flush;
    assign bus.rempty = (st_cnt == 2'd0);
    assign bus.rvalid = !bus.rempty;
    assign bus.rdata  = st0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_cnt   <= 2'd0;
        inflight <= 1'b0;
        st0      <= '0;
        st1      <= '0;
      end else if (bus.flush) begin
        st_cnt   <= 2'd0;
        inflight <= 1'b0;
        st0      <= '0;
        st1      <= '0;
      end else begin
        st_cnt   <= st_next;
        inflight <= bus.ram_re;
        case ({pop, inflight})
          2'b11: begin
            if (st_cnt == 2'd2) begin
              st0 <= st1;
              st1 <= bus.ram_rdata;
            end else begin
              st0 <= bus.ram_rdata;
            end
          end
          2'b10: st0 <= st1;
          2'b01: begin
            if (st_cnt == 2'd0)
              st0 <= bus.ram_rdata;
            else
              st1 <= bus.ram_rdata;
          end
          default: ;
        endcase
      end
    end
  end else begin : g_std
    logic                    rvalid_q;
    logic [c_DATA_WIDTH-1:0] rdata_q;

    assign bus.ram_re = pop;
    assign bus.rempty = (level == '0);
    assign bus.rvalid = rvalid_q;
    // RAM data is presented in its valid cycle and held afterwards
    assign bus.rdata  = rvalid_q ? bus.ram_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else if (bus.flush) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= pop;
        if (rvalid_q)
          rdata_q <= bus.ram_rdata;
      end
    end
  end

`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.w_en && bus.wfull)
        ovf_q <= 1'b1;
      else if (bus.clr_err)
        ovf_q <= 1'b0;
      if (bus.r_en && bus.rempty)
        unf_q <= 1'b1;
      else if (bus.clr_err)
        unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ipm_sfifo_ctrl_v2.sv
// tb/tb_ipm_sfifo_ctrl_v2.sv - directed bench for standard and FWFT instances of ipm_sfifo_ctrl_v2
module tb_ipm_sfifo_ctrl_v2;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_err;
  logic [7:0] s_wdata;
  logic [7:0] f_wdata;
  logic [7:0] s_next;
  logic [7:0] s_mem [16];
  logic [7:0] f_mem [16];

  always #5 clk = ~clk;

  ipm_sfifo_ctrl_v2_if #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8)) s_if ();
  ipm_sfifo_ctrl_v2_if #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8)) f_if ();

  ipm_sfifo_ctrl_v2 #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT("OFF")) u_std (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  ipm_sfifo_ctrl_v2 #(.c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT("ON")) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(f_if.slave));

  // Synchronous-read RAMs: data valid the cycle after ram_re
  always @(posedge clk) begin
    if (s_if.ram_we) s_mem[s_if.waddr] <= s_wdata;
    if (s_if.ram_re) s_if.ram_rdata <= s_mem[s_if.raddr];
    if (f_if.ram_we) f_mem[f_if.waddr] <= f_wdata;
    if (f_if.ram_re) f_if.ram_rdata <= f_mem[f_if.raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_write(input int n);
    for (int i = 0; i < n; i++) begin
      s_if.w_en = 1'b1;
      s_wdata   = s_next;
      s_next    = s_next + 8'd1;
      step();
    end
    s_if.w_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FIFO_CTRL_ERR_FLAG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    s_wdata = 8'h00; f_wdata = 8'h00; s_next = 8'h00;
    s_if.flush = 0; s_if.w_en = 0; s_if.r_en = 0; s_if.clr_err = 0;
    s_if.af_thresh = 5'd12; s_if.ae_thresh = 5'd3;
    f_if.flush = 0; f_if.w_en = 0; f_if.r_en = 0; f_if.clr_err = 0;
    f_if.af_thresh = 5'd12; f_if.ae_thresh = 5'd3;
    #1;
    chk("rst_level", s_if.water_level, 0);
    chk("rst_rempty", s_if.rempty, 1);
    chk("rst_wfull", s_if.wfull, 0);
    chk("rst_rvalid", s_if.rvalid, 0);
    chk("rst_rdata", s_if.rdata, 0);
    chk("rst_ae", s_if.almost_empty, 1);
    chk("rst_af", s_if.almost_full, 0);
    chk("rst_ovf", s_if.overflow, 0);
    chk("rst_f_rempty", f_if.rempty, 1);
    chk("rst_f_rvalid", f_if.rvalid, 0);
    chk("rst_f_rdata", f_if.rdata, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // standard mode: fill to full
    for (int i = 0; i < 16; i++) begin
      s_if.w_en = 1'b1;
      s_wdata   = 8'(i);
      #1;
      chk("s_fill_we", s_if.ram_we, 1);
      chk("s_fill_waddr", s_if.waddr, i);
      step();
    end
    chk("s_full_level", s_if.water_level, 16);
    chk("s_full_wfull", s_if.wfull, 1);
    chk("s_full_af", s_if.almost_full, 1);
    chk("s_full_ae", s_if.almost_empty, 0);
    s_wdata = 8'hEE;
    #1;
    chk("s_ovf_no_we", s_if.ram_we, 0);
    step();
    s_if.w_en = 1'b0;
    chk("s_ovf_level", s_if.water_level, 16);
    chk("s_ovf_flag", s_if.overflow, exp_err);
    s_if.clr_err = 1'b1;
    step();
    s_if.clr_err = 1'b0;
    chk("s_ovf_clr", s_if.overflow, 0);

    // drain: data one cycle after each ram_re
    for (int i = 0; i < 16; i++) begin
      s_if.r_en = 1'b1;
      #1;
      chk("s_pop_re", s_if.ram_re, 1);
      chk("s_pop_raddr", s_if.raddr, i);
      step();
      chk("s_pop_rvalid", s_if.rvalid, 1);
      chk("s_pop_rdata", s_if.rdata, i);
    end
    s_if.r_en = 1'b0;
    chk("s_drain_rempty", s_if.rempty, 1);
    chk("s_drain_level", s_if.water_level, 0);
    step();
    chk("s_idle_rvalid", s_if.rvalid, 0);
    chk("s_hold_rdata", s_if.rdata, 8'h0F);

    // empty with w_en and r_en: write only
    s_if.w_en = 1'b1; s_if.r_en = 1'b1; s_wdata = 8'h20; s_next = 8'h21;
    #1;
    chk("s_both_empty_re", s_if.ram_re, 0);
    chk("s_both_empty_we", s_if.ram_we, 1);
    step();
    s_if.w_en = 1'b0; s_if.r_en = 1'b0;
    chk("s_both_empty_level", s_if.water_level, 1);
    chk("s_unf_flag", s_if.underflow, exp_err);
    s_if.clr_err = 1'b1;
    step();
    s_if.clr_err = 1'b0;
    chk("s_unf_clr", s_if.underflow, 0);

    // thresholds af=12 ae=3
    s_write(2);
    chk("thr3_ae", s_if.almost_empty, 1);
    chk("thr3_af", s_if.almost_full, 0);
    s_write(1);
    chk("thr4_ae", s_if.almost_empty, 0);
    chk("thr4_af", s_if.almost_full, 0);
    s_write(7);
    chk("thr11_ae", s_if.almost_empty, 0);
    chk("thr11_af", s_if.almost_full, 0);
    s_write(1);
    chk("thr12_ae", s_if.almost_empty, 0);
    chk("thr12_af", s_if.almost_full, 1);

    // down to 9, then flush with w_en
    s_if.r_en = 1'b1;
    step(); step(); step();
    s_if.r_en = 1'b0;
    chk("s_pre_flush_level", s_if.water_level, 9);
    s_if.flush = 1'b1; s_if.w_en = 1'b1;
    #1;
    chk("s_flush_we", s_if.ram_we, 0);
    chk("s_flush_re", s_if.ram_re, 0);
    step();
    s_if.flush = 1'b0; s_if.w_en = 1'b0;
    chk("s_flush_level", s_if.water_level, 0);
    chk("s_flush_rempty", s_if.rempty, 1);
    chk("s_flush_rvalid", s_if.rvalid, 0);

    // wrap: 40 write/pop pairs at level 5
    s_next = 8'h40;
    s_write(5);
    chk("s_wrap_start", s_if.water_level, 5);
    for (int i = 0; i < 40; i++) begin
      s_if.w_en = 1'b1; s_if.r_en = 1'b1;
      s_wdata = 8'(8'h45 + i);
      #1;
      chk("s_wrap_waddr", s_if.waddr, (5 + i) % 16);
      step();
      chk("s_wrap_rvalid", s_if.rvalid, 1);
      chk("s_wrap_rdata", s_if.rdata, 8'h40 + i);
    end
    s_if.r_en = 1'b0;
    chk("s_wrap_level", s_if.water_level, 5);

    // reset in the middle of a write burst
    s_wdata = 8'h99;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s_mid_rst_level", s_if.water_level, 0);
    chk("s_mid_rst_rempty", s_if.rempty, 1);
    chk("s_mid_rst_rvalid", s_if.rvalid, 0);
    chk("s_mid_rst_rdata", s_if.rdata, 0);
    chk("s_mid_rst_wfull", s_if.wfull, 0);
    chk("s_mid_rst_ovf", s_if.overflow, 0);
    chk("s_mid_rst_ae", s_if.almost_empty, 1);
    step();
    rst_n = 1'b1;
    #1;
    chk("s_post_rst_we", s_if.ram_we, 1);
    chk("s_post_rst_waddr", s_if.waddr, 0);
    step();
    s_if.w_en = 1'b0;
    chk("s_post_rst_level", s_if.water_level, 1);

    // FWFT: single-word latency
    f_if.w_en = 1'b1; f_wdata = 8'hA5;
    step();
    f_if.w_en = 1'b0;
    chk("f_k0_rempty", f_if.rempty, 1);
    chk("f_k0_level", f_if.water_level, 1);
    step();
    chk("f_k1_rempty", f_if.rempty, 1);
    step();
    chk("f_k2_rempty", f_if.rempty, 0);
    chk("f_k2_rvalid", f_if.rvalid, 1);
    chk("f_k2_rdata", f_if.rdata, 8'hA5);
    f_if.r_en = 1'b1;
    step();
    f_if.r_en = 1'b0;
    chk("f_pop_rempty", f_if.rempty, 1);
    chk("f_pop_level", f_if.water_level, 0);
    chk("f_pop_rvalid", f_if.rvalid, 0);

    // FWFT: fill to 10, burst-read with no bubbles
    for (int i = 0; i < 10; i++) begin
      f_if.w_en = 1'b1;
      f_wdata = 8'(8'h10 + i);
      step();
    end
    f_if.w_en = 1'b0;
    step(); step(); step();
    chk("f_burst_level", f_if.water_level, 10);
    for (int i = 0; i < 10; i++) begin
      f_if.r_en = 1'b1;
      #1;
      chk("f_burst_rvalid", f_if.rvalid, 1);
      chk("f_burst_rdata", f_if.rdata, 8'h10 + i);
      step();
    end
    f_if.r_en = 1'b0;
    chk("f_burst_rempty", f_if.rempty, 1);
    chk("f_burst_end_level", f_if.water_level, 0);

    // FWFT: flush discards output stage and in-flight read
    for (int i = 0; i < 3; i++) begin
      f_if.w_en = 1'b1;
      f_wdata = 8'(8'h30 + i);
      step();
    end
    f_if.w_en = 1'b0;
    step(); step();
    f_if.flush = 1'b1; f_if.w_en = 1'b1; f_if.r_en = 1'b1;
    #1;
    chk("f_flush_we", f_if.ram_we, 0);
    chk("f_flush_re", f_if.ram_re, 0);
    step();
    f_if.flush = 1'b0; f_if.w_en = 1'b0; f_if.r_en = 1'b0;
    chk("f_flush_rempty", f_if.rempty, 1);
    chk("f_flush_level", f_if.water_level, 0);
    chk("f_flush_rdata", f_if.rdata, 0);
    f_if.w_en = 1'b1; f_wdata = 8'h77;
    #1;
    chk("f_post_flush_waddr", f_if.waddr, 0);
    step();
    f_if.w_en = 1'b0;
    step(); step();
    chk("f_post_flush_rempty", f_if.rempty, 0);
    chk("f_post_flush_rdata", f_if.rdata, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
